trivia_feed_ctrl: RTL and testbench
===================================

TRIVIA_FEED_CTRL -- requirements
Module: trivia_feed_ctrl

Interface
REQ-001 Parameter AW, default 12, address width of the AD, message and output memories.
REQ-002 Parameter START_CYCLES, default 2, number of cycles start_core is held high.
REQ-003 Parameter TAG_WORDS, default 2, count of 64-bit tag words emitted after the ciphertext when encrypting.
REQ-004 Parameter TIMEOUT, default 4096, maximum number of idle RUN cycles tolerated without a core event.
REQ-005 clk  in  1  sole clock; all logic is on the rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 go  in  1  single-cycle request to start an operation; sampled only in IDLE.
REQ-008 enc_dec_in  in  1  1 = encrypt, 0 = decrypt; latched on an accepted go.
REQ-009 ad_len, msg_len  in  64 each  byte lengths; latched on an accepted go.
REQ-010 shift_data_in_block, debug_dataMode, writeToMem  in  1 each  core strobes.
REQ-011 cipher_text  in  64  core output word.
REQ-012 start_core, encDec  out  1 each  core controls.
REQ-013 adLen, msgLen  out  64 each  latched lengths driven to the core.
REQ-014 ad_addr, msg_addr  out  AW each  read addresses into the AD and message memories.
REQ-015 out_we  out  1; out_addr  out  AW; out_data  out  64  output memory write port.
REQ-016 busy, done, error  out  1 each  status outputs.

Function
REQ-017 The FSM SHALL have the states IDLE, START, RUN, DONE and ERR.
REQ-018 IDLE: on go, latch the inputs, clear both read addresses, out_addr and the word counter, and enter START.
REQ-019 START: assert start_core for exactly START_CYCLES cycles, then enter RUN.
REQ-020 Expected word count: exp = ceil(msg_len/8) + (encDec ? TAG_WORDS : 0); the computation SHALL be 64-bit and the ceiling SHALL be formed with a +7 before the shift.
REQ-021 In RUN, shift_data_in_block & debug_dataMode SHALL increment msg_addr in the next cycle.
REQ-022 In RUN, shift_data_in_block & ~debug_dataMode SHALL increment ad_addr in the next cycle.
REQ-023 In RUN, writeToMem SHALL, in the same cycle, drive out_we=1, out_data=cipher_text and out_addr=current count; the count SHALL increment on the following edge.
REQ-024 When a write raises the count to exp, the FSM SHALL enter DONE on that edge.
REQ-025 When exp is 0, the FSM SHALL enter DONE on the first RUN cycle.
REQ-026 The watchdog SHALL reset on any strobe; TIMEOUT consecutive cycles without a strobe SHALL move the FSM to ERR.
REQ-027 DONE and ERR SHALL hold done or error high until the next accepted go, which restarts the FSM as in IDLE.
REQ-028 busy SHALL be 1 in START and RUN.
REQ-029 go SHALL be ignored in START and RUN.
REQ-030 Addresses SHALL wrap modulo 2^AW when REQ-035 is inactive.
REQ-031 Strobes arriving outside RUN SHALL be ignored: no address change and out_we=0.

Reset
REQ-032 On reset the FSM SHALL enter IDLE, overriding every other event in the same cycle, including mid-RUN.
REQ-033 All outputs SHALL reset to 0 (start_core, encDec, adLen, msgLen, addresses, out_*, busy, done, error).

Configuration
REQ-034 Macro TRIVIA_ADDR_BOUND_CHECK_EN SHALL select the behaviour of REQ-035.
REQ-035 With the macro defined, an increment of ad_addr, msg_addr or the output count past 2^AW-1 SHALL enter ERR instead of wrapping.
REQ-036 With the macro undefined, the wrap behaviour of REQ-030 SHALL apply and no bound-check logic SHALL exist.

Structure
REQ-037 The package trivia_pkg SHALL hold the FSM state enum, TAG_WORDS_DEF=2 and the word-count function of REQ-020.
REQ-038 The watchdog SHALL be the sub-module trivia_watchdog (parameter TIMEOUT; inputs kick and enable; output expired).

Verification
REQ-039 Encrypt: ad_len=16, msg_len=16, go -> start_core high 2 cycles, ad_addr 0->2, msg_addr 0->2, 4 writes at out_addr 0..3, then done=1.
REQ-040 Decrypt: msg_len=9 -> exp=2; done after the 2nd writeToMem; a 3rd writeToMem is ignored.
REQ-041 Hang: no strobes after START -> error=1 exactly TIMEOUT cycles after RUN entry.
REQ-042 Reset asserted mid-RUN at ad_addr=5 -> next cycle all outputs 0, state IDLE; the following go operates normally.
REQ-043 AW=2 with 6 AD shifts: macro defined -> ERR on the 4th shift; macro undefined -> ad_addr wraps to 2.
REQ-044 msg_len=0, decrypt -> done=1 one cycle after RUN entry with no out_we.

Source files
------------

// File: rtl/trivia_pkg.sv
// Shared types and helpers for the Trivium feed controller: FSM state encoding,
// default tag length and the expected output word count.
package trivia_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_RUN,
      ST_DONE,
      ST_ERR
   } state_t;

   localparam int TAG_WORDS_DEF = 2;

   // Ciphertext words plus the tag words appended only when encrypting.
   function automatic logic [63:0] word_count(input logic [63:0] len,
                                              input logic        enc,
                                              input logic [63:0] tag_words);
      logic [63:0] w_words;
      w_words = (len + 64'd7) >> 3;
      return enc ? (w_words + tag_words) : w_words;
   endfunction

endpackage

// File: rtl/trivia_watchdog.sv
// Idle-cycle watchdog: counts consecutive enabled cycles without a kick and
// flags expiry on the TIMEOUT-th such cycle.
module trivia_watchdog #(
   parameter int TIMEOUT = 4096
) (
   input  logic clk,
   input  logic reset,
   input  logic kick,
   input  logic enable,
   output logic expired
);

   localparam int CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (reset || !enable || kick) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   // r_cnt holds the idle cycles already seen, so the current idle cycle is the last one.
   assign expired = enable & ~kick & (r_cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/trivia_feed_ctrl.sv
// Sequencer feeding AD/message words into a Trivium core and collecting its output words.
// Optional macro TRIVIA_ADDR_BOUND_CHECK_EN turns address/count overflow into an error.
module trivia_feed_ctrl
   import trivia_pkg::*;
#(
   parameter int AW           = 12,
   parameter int START_CYCLES = 2,
   parameter int TAG_WORDS    = TAG_WORDS_DEF,
   parameter int TIMEOUT      = 4096
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          go,
   input  logic          enc_dec_in,
   input  logic [63:0]   ad_len,
   input  logic [63:0]   msg_len,
   input  logic          shift_data_in_block,
   input  logic          debug_dataMode,
   input  logic          writeToMem,
   input  logic [63:0]   cipher_text,
   output logic          start_core,
   output logic          encDec,
   output logic [63:0]   adLen,
   output logic [63:0]   msgLen,
   output logic [AW-1:0] ad_addr,
   output logic [AW-1:0] msg_addr,
   output logic          out_we,
   output logic [AW-1:0] out_addr,
   output logic [63:0]   out_data,
   output logic          busy,
   output logic          done,
   output logic          error
);

   state_t        r_state;
   state_t        w_next;
   logic [15:0]   r_start_cnt;
   logic          r_encDec;
   logic [63:0]   r_adLen;
   logic [63:0]   r_msgLen;
   logic [AW-1:0] r_ad_addr;
   logic [AW-1:0] r_msg_addr;
   logic [63:0]   r_count;

   logic          w_run;
   logic          w_accept;
   logic          w_ad_inc;
   logic          w_msg_inc;
   logic          w_wr;
   logic          w_kick;
   logic          w_expired;
   logic [63:0]   w_exp;
   logic          w_last_wr;

   assign w_run     = (r_state == ST_RUN);
   assign w_accept  = go & (r_state != ST_START) & (r_state != ST_RUN);
   assign w_ad_inc  = w_run & shift_data_in_block & ~debug_dataMode;
   assign w_msg_inc = w_run & shift_data_in_block & debug_dataMode;
   assign w_wr      = w_run & writeToMem;
   // debug_dataMode is a phase level, not an event, so it does not feed the watchdog.
   assign w_kick    = shift_data_in_block | writeToMem;

   assign w_exp     = word_count(r_msgLen, r_encDec, 64'(TAG_WORDS));
   assign w_last_wr = w_wr & ((r_count + 64'd1) == w_exp);

`ifdef TRIVIA_ADDR_BOUND_CHECK_EN
   localparam logic [63:0] CNT_MAX = (64'd1 << AW) - 64'd1;

   logic w_bound_err;

   // A write that completes the transfer at the top address is legal, not an overflow.
   assign w_bound_err = (w_ad_inc  & (&r_ad_addr))
                      | (w_msg_inc & (&r_msg_addr))
                      | (w_wr & ~w_last_wr & (r_count == CNT_MAX));
`endif

   trivia_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .clk     (clk),
      .reset   (reset),
      .kick    (w_kick),
      .enable  (w_run),
      .expired (w_expired)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE, ST_DONE, ST_ERR: begin
            if (go) w_next = ST_START;
         end
         ST_START: begin
            if (r_start_cnt == 16'(START_CYCLES - 1)) w_next = ST_RUN;
         end
         ST_RUN: begin
            if (w_exp == 64'd0) begin
               w_next = ST_DONE;
            end else if (w_last_wr) begin
               w_next = ST_DONE;
`ifdef TRIVIA_ADDR_BOUND_CHECK_EN
            end else if (w_bound_err) begin
               w_next = ST_ERR;
`endif
            end else if (w_expired) begin
               w_next = ST_ERR;
            end
         end
         default: w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_start_cnt <= '0;
         r_encDec    <= 1'b0;
         r_adLen     <= '0;
         r_msgLen    <= '0;
         r_ad_addr   <= '0;
         r_msg_addr  <= '0;
         r_count     <= '0;
      end else if (w_accept) begin
         r_start_cnt <= '0;
         r_encDec    <= enc_dec_in;
         r_adLen     <= ad_len;
         r_msgLen    <= msg_len;
         r_ad_addr   <= '0;
         r_msg_addr  <= '0;
         r_count     <= '0;
      end else begin
         if (r_state == ST_START) r_start_cnt <= r_start_cnt + 16'd1;
         if (w_ad_inc)            r_ad_addr   <= r_ad_addr + 1'b1;
         if (w_msg_inc)           r_msg_addr  <= r_msg_addr + 1'b1;
         if (w_wr)                r_count     <= r_count + 64'd1;
      end
   end

   assign start_core = (r_state == ST_START);
   assign busy       = (r_state == ST_START) | w_run;
   assign done       = (r_state == ST_DONE);
   assign error      = (r_state == ST_ERR);
   assign encDec     = r_encDec;
   assign adLen      = r_adLen;
   assign msgLen     = r_msgLen;
   assign ad_addr    = r_ad_addr;
   assign msg_addr   = r_msg_addr;
   assign out_we     = w_wr;
   assign out_addr   = r_count[AW-1:0];
   assign out_data   = w_wr ? cipher_text : 64'd0;

endmodule

// File: tb/tb_trivia_feed_ctrl.sv
// Directed bench for trivia_feed_ctrl: a default-width instance plus an AW=2 instance
// sharing the same stimulus, the latter exercising address wrap/overflow.
module tb_trivia_feed_ctrl;

   localparam int TO = 16;

   logic        clk = 1'b0;
   logic        reset;
   logic        go;
   logic        enc_dec_in;
   logic [63:0] ad_len;
   logic [63:0] msg_len;
   logic        shift_data_in_block;
   logic        debug_dataMode;
   logic        writeToMem;
   logic [63:0] cipher_text;

   logic        a_start_core, a_encDec, a_out_we, a_busy, a_done, a_error;
   logic [63:0] a_adLen, a_msgLen, a_out_data;
   logic [11:0] a_ad_addr, a_msg_addr, a_out_addr;

   logic        b_start_core, b_encDec, b_out_we, b_busy, b_done, b_error;
   logic [63:0] b_adLen, b_msgLen, b_out_data;
   logic [1:0]  b_ad_addr, b_msg_addr, b_out_addr;

   int n_checks = 0;
   int n_errs   = 0;

   logic        seen_we;
   logic [11:0] seen_addr;
   logic [63:0] seen_data;

   always #5 clk = ~clk;

   trivia_feed_ctrl #(.AW(12), .START_CYCLES(2), .TAG_WORDS(2), .TIMEOUT(TO)) u_dut_a (
      .clk(clk), .reset(reset), .go(go), .enc_dec_in(enc_dec_in),
      .ad_len(ad_len), .msg_len(msg_len),
      .shift_data_in_block(shift_data_in_block), .debug_dataMode(debug_dataMode),
      .writeToMem(writeToMem), .cipher_text(cipher_text),
      .start_core(a_start_core), .encDec(a_encDec), .adLen(a_adLen), .msgLen(a_msgLen),
      .ad_addr(a_ad_addr), .msg_addr(a_msg_addr),
      .out_we(a_out_we), .out_addr(a_out_addr), .out_data(a_out_data),
      .busy(a_busy), .done(a_done), .error(a_error)
   );

   trivia_feed_ctrl #(.AW(2), .START_CYCLES(2), .TAG_WORDS(2), .TIMEOUT(TO)) u_dut_b (
      .clk(clk), .reset(reset), .go(go), .enc_dec_in(enc_dec_in),
      .ad_len(ad_len), .msg_len(msg_len),
      .shift_data_in_block(shift_data_in_block), .debug_dataMode(debug_dataMode),
      .writeToMem(writeToMem), .cipher_text(cipher_text),
      .start_core(b_start_core), .encDec(b_encDec), .adLen(b_adLen), .msgLen(b_msgLen),
      .ad_addr(b_ad_addr), .msg_addr(b_msg_addr),
      .out_we(b_out_we), .out_addr(b_out_addr), .out_data(b_out_data),
      .busy(b_busy), .done(b_done), .error(b_error)
   );

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errs++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // One strobe cycle; the combinational write port is captured before the edge.
   task automatic pulse(input logic sh, input logic dm, input logic wr, input logic [63:0] ct);
      shift_data_in_block = sh;
      debug_dataMode      = dm;
      writeToMem          = wr;
      cipher_text         = ct;
      #1;
      seen_we   = a_out_we;
      seen_addr = a_out_addr;
      seen_data = a_out_data;
      tick();
      shift_data_in_block = 1'b0;
      debug_dataMode      = 1'b0;
      writeToMem          = 1'b0;
      cipher_text         = 64'd0;
   endtask

   task automatic launch(input logic enc, input logic [63:0] al, input logic [63:0] ml);
      enc_dec_in = enc;
      ad_len     = al;
      msg_len    = ml;
      go         = 1'b1;
      tick();
      go = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      go = 1'b0;
      enc_dec_in = 1'b0;
      ad_len = 64'd0;
      msg_len = 64'd0;
      shift_data_in_block = 1'b0;
      debug_dataMode = 1'b0;
      writeToMem = 1'b0;
      cipher_text = 64'd0;
      tick();
      tick();
      reset = 1'b0;

      chk("rst_start_core", 64'(a_start_core), 64'd0);
      chk("rst_busy",       64'(a_busy),       64'd0);
      chk("rst_done",       64'(a_done),       64'd0);
      chk("rst_error",      64'(a_error),      64'd0);
      chk("rst_ad_addr",    64'(a_ad_addr),    64'd0);
      chk("rst_out_we",     64'(a_out_we),     64'd0);

      // Encrypt: 16-byte message -> 2 cipher words + 2 tag words.
      launch(1'b1, 64'd16, 64'd16);
      chk("enc_start1",  64'(a_start_core), 64'd1);
      chk("enc_busy",    64'(a_busy),       64'd1);
      chk("enc_encDec",  64'(a_encDec),     64'd1);
      chk("enc_adLen",   a_adLen,           64'd16);
      chk("enc_msgLen",  a_msgLen,          64'd16);
      tick();
      chk("enc_start2",  64'(a_start_core), 64'd1);
      tick();
      chk("enc_run_nostart", 64'(a_start_core), 64'd0);
      chk("enc_run_busy",    64'(a_busy),       64'd1);
      pulse(1'b1, 1'b0, 1'b0, 64'd0);
      pulse(1'b1, 1'b0, 1'b0, 64'd0);
      chk("enc_ad_addr",  64'(a_ad_addr),  64'd2);
      chk("enc_msg_addr0", 64'(a_msg_addr), 64'd0);
      pulse(1'b1, 1'b1, 1'b0, 64'd0);
      pulse(1'b1, 1'b1, 1'b0, 64'd0);
      chk("enc_msg_addr", 64'(a_msg_addr), 64'd2);
      chk("enc_ad_hold",  64'(a_ad_addr),  64'd2);
      for (int i = 0; i < 4; i++) begin
         pulse(1'b0, 1'b0, 1'b1, 64'hC0DE_0000_0000_A000 + 64'(i));
         chk("enc_we",   64'(seen_we),   64'd1);
         chk("enc_addr", 64'(seen_addr), 64'(i));
         chk("enc_data", seen_data,      64'hC0DE_0000_0000_A000 + 64'(i));
         if (i == 2) chk("enc_not_done_yet", 64'(a_done), 64'd0);
      end
      chk("enc_done",      64'(a_done), 64'd1);
      chk("enc_done_busy", 64'(a_busy), 64'd0);
      pulse(1'b1, 1'b0, 1'b1, 64'hDEAD);
      chk("done_ign_we",   64'(seen_we),    64'd0);
      chk("done_ign_ad",   64'(a_ad_addr),  64'd2);
      chk("done_ign_oa",   64'(a_out_addr), 64'd4);
      chk("done_hold",     64'(a_done),     64'd1);

      // Decrypt: 9 bytes -> ceil(9/8) = 2 words, no tag.
      launch(1'b0, 64'd0, 64'd9);
      chk("dec_clr_ad", 64'(a_ad_addr),  64'd0);
      chk("dec_clr_oa", 64'(a_out_addr), 64'd0);
      chk("dec_done_clr", 64'(a_done), 64'd0);
      pulse(1'b0, 1'b0, 1'b1, 64'h11);
      chk("dec_go_ignored_start", 64'(seen_we), 64'd0);
      tick();
      chk("dec_encDec", 64'(a_encDec), 64'd0);
      pulse(1'b0, 1'b0, 1'b1, 64'h1111);
      chk("dec_w1_we", 64'(seen_we), 64'd1);
      chk("dec_w1_done", 64'(a_done), 64'd0);
      pulse(1'b0, 1'b0, 1'b1, 64'h2222);
      chk("dec_w2_addr", 64'(seen_addr), 64'd1);
      chk("dec_w2_done", 64'(a_done), 64'd1);
      pulse(1'b0, 1'b0, 1'b1, 64'h3333);
      chk("dec_w3_ign", 64'(seen_we), 64'd0);
      chk("dec_w3_oa",  64'(a_out_addr), 64'd2);

      // Hang: no strobes once in RUN.
      launch(1'b1, 64'd0, 64'd8);
      tick();
      tick();
      chk("hang_in_run", 64'(a_busy), 64'd1);
      for (int i = 1; i < TO; i++) tick();
      chk("hang_not_yet", 64'(a_error), 64'd0);
      tick();
      chk("hang_error", 64'(a_error), 64'd1);
      chk("hang_busy",  64'(a_busy),  64'd0);

      // Reset mid-RUN while a strobe is present.
      launch(1'b1, 64'd32, 64'd64);
      tick();
      tick();
      for (int i = 0; i < 5; i++) pulse(1'b1, 1'b0, 1'b0, 64'd0);
      pulse(1'b1, 1'b1, 1'b0, 64'd0);
      pulse(1'b0, 1'b0, 1'b1, 64'h55);
      chk("pre_rst_ad", 64'(a_ad_addr), 64'd5);
      reset = 1'b1;
      shift_data_in_block = 1'b1;
      writeToMem = 1'b1;
      tick();
      reset = 1'b0;
      shift_data_in_block = 1'b0;
      writeToMem = 1'b0;
      #1;
      chk("mrst_ad",     64'(a_ad_addr),    64'd0);
      chk("mrst_msg",    64'(a_msg_addr),   64'd0);
      chk("mrst_oa",     64'(a_out_addr),   64'd0);
      chk("mrst_we",     64'(a_out_we),     64'd0);
      chk("mrst_data",   a_out_data,        64'd0);
      chk("mrst_busy",   64'(a_busy),       64'd0);
      chk("mrst_start",  64'(a_start_core), 64'd0);
      chk("mrst_encDec", 64'(a_encDec),     64'd0);
      chk("mrst_adLen",  a_adLen,           64'd0);
      chk("mrst_msgLen", a_msgLen,          64'd0);
      chk("mrst_done",   64'(a_done),       64'd0);
      chk("mrst_error",  64'(a_error),      64'd0);

      // Zero-length decrypt after reset.
      launch(1'b0, 64'd0, 64'd0);
      chk("z_start", 64'(a_start_core), 64'd1);
      tick();
      tick();
      #1;
      chk("z_run_we",   64'(a_out_we), 64'd0);
      chk("z_run_busy", 64'(a_busy),   64'd1);
      chk("z_run_done", 64'(a_done),   64'd0);
      tick();
      chk("z_done", 64'(a_done), 64'd1);

      // AW=2 instance: six AD shifts.
      launch(1'b1, 64'd48, 64'd64);
      tick();
      tick();
      for (int i = 0; i < 3; i++) pulse(1'b1, 1'b0, 1'b0, 64'd0);
      chk("aw2_ad3",  64'(b_ad_addr), 64'd3);
      chk("aw2_err3", 64'(b_error),   64'd0);
      pulse(1'b1, 1'b0, 1'b0, 64'd0);
`ifdef TRIVIA_ADDR_BOUND_CHECK_EN
      chk("aw2_err4", 64'(b_error), 64'd1);
`else
      chk("aw2_wrap4", 64'(b_ad_addr), 64'd0);
      chk("aw2_err4",  64'(b_error),   64'd0);
`endif
      pulse(1'b1, 1'b0, 1'b0, 64'd0);
      pulse(1'b1, 1'b0, 1'b0, 64'd0);
`ifdef TRIVIA_ADDR_BOUND_CHECK_EN
      chk("aw2_err6", 64'(b_error), 64'd1);
`else
      chk("aw2_ad6",  64'(b_ad_addr), 64'd2);
      chk("aw2_err6", 64'(b_error),   64'd0);
`endif
      chk("aw12_ad6", 64'(a_ad_addr), 64'd6);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
      $finish;
   end

endmodule
